// File: rtl/chi_link_pkg.sv
// Shared types for the CHI link-layer activation controller.
//   link_st_t       : four-state link handshake encoding (STOP/ACT/RUN/DEACT)
//   chi_link_pair_t : per-link {tx, rx} state pair, packed as link_state nibble
//   CRD_W           : width of the L-credit counters
package chi_link_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      ACT   = 2'd1,
      RUN   = 2'd2,
      DEACT = 2'd3
   } link_st_t;

   typedef struct packed {
      link_st_t tx;
      link_st_t rx;
   } chi_link_pair_t;

   localparam int CRD_W = 4;

endpackage

// File: rtl/chi_link_lane.sv
// One CHI link: local TX link FSM with L-credit count, remote-driven RX link
// FSM with outstanding-grant count, and a sticky handshake timeout.
// Ports:
//   ACLK, ARESETn                        clock, synchronous active-low reset
//   tx_up_req                            protocol request for TX link up/down
//   txlinkactivereq / txlinkactiveack    TX activation handshake pins
//   txlcrdv, tx_flit_send                credit grant in, flit send from protocol
//   tx_flit_ok, tx_crd_return            send permission, credit-return pulse
//   rxlinkactivereq / rxlinkactiveack    RX activation handshake pins
//   rx_accept, rxlcrdv, rx_flitv         RX permission, credit grant out, flit in
//   timeout_err                          sticky handshake timeout flag
//   state                                {tx, rx} FSM states
module chi_link_lane
   import chi_link_pkg::*;
#(
   parameter int MAX_CRD = 15,
   parameter int TIMEOUT = 1023
) (
   input  logic           ACLK,
   input  logic           ARESETn,
   input  logic           tx_up_req,
   output logic           txlinkactivereq,
   input  logic           txlinkactiveack,
   input  logic           txlcrdv,
   input  logic           tx_flit_send,
   output logic           tx_flit_ok,
   output logic           tx_crd_return,
   input  logic           rxlinkactivereq,
   output logic           rxlinkactiveack,
   input  logic           rx_accept,
   output logic           rxlcrdv,
   input  logic           rx_flitv,
   output logic           timeout_err,
   output chi_link_pair_t state
);

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(MAX_CRD);
   localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);

   link_st_t         tx_st, tx_nxt;
   link_st_t         rx_st, rx_nxt;
   logic [CRD_W-1:0] tcrd, tcrd_nxt;
   logic [CRD_W-1:0] ocrd, ocrd_nxt;
   logic [TO_W-1:0]  to_cnt, to_nxt;
   logic             err_q, err_nxt;
   logic             counting;

   // Saturating up/down credit update; simultaneous inc and dec cancel, and a
   // decrement at zero is dropped rather than wrapping.
   function automatic logic [CRD_W-1:0] crd_upd(input logic [CRD_W-1:0] cur,
                                                 input logic inc,
                                                 input logic dec);
      logic [CRD_W-1:0] r;
      r = cur;
      if (inc && !dec && (cur < CRD_MAX))
         r = cur + 1'b1;
      else if (dec && !inc && (cur != '0))
         r = cur - 1'b1;
      return r;
   endfunction

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         tx_st  <= STOP;
         rx_st  <= STOP;
         tcrd   <= '0;
         ocrd   <= '0;
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         tx_st  <= tx_nxt;
         rx_st  <= rx_nxt;
         tcrd   <= tcrd_nxt;
         ocrd   <= ocrd_nxt;
         to_cnt <= to_nxt;
         err_q  <= err_nxt;
      end
   end

   always_comb begin
      tx_nxt   = tx_st;
      rx_nxt   = rx_st;
      tcrd_nxt = tcrd;
      ocrd_nxt = ocrd;

      txlinkactivereq = (tx_st == ACT) || (tx_st == RUN);
      tx_flit_ok      = (tx_st == RUN) && (tcrd != '0);
      tx_crd_return   = (tx_st == DEACT) && (tcrd != '0);
      rxlinkactiveack = (rx_st == RUN) || (rx_st == DEACT);
      rxlcrdv         = (rx_st == RUN) && (ocrd < CRD_MAX) && rxlinkactivereq;

      case (tx_st)
         STOP:  if (tx_up_req && !txlinkactiveack) tx_nxt = ACT;
         ACT:   if (txlinkactiveack) tx_nxt = RUN;
         RUN: begin
            tcrd_nxt = crd_upd(tcrd, txlcrdv, tx_flit_send && tx_flit_ok);
            if (!tx_up_req) tx_nxt = DEACT;
         end
         DEACT: begin
            // Every cycle with credits left emits a credit-return flit.
            tcrd_nxt = crd_upd(tcrd, txlcrdv, tx_crd_return);
            if (!txlinkactiveack && (tcrd == '0)) begin
               tx_nxt   = STOP;
               tcrd_nxt = '0;
            end
         end
      endcase

      case (rx_st)
         STOP:  if (rxlinkactivereq && rx_accept) rx_nxt = ACT;
         ACT:   rx_nxt = RUN;
         RUN: begin
            ocrd_nxt = crd_upd(ocrd, rxlcrdv, rx_flitv);
            if (!rxlinkactivereq) rx_nxt = DEACT;
         end
         DEACT: begin
            ocrd_nxt = crd_upd(ocrd, 1'b0, rx_flitv);
            if (ocrd == '0) rx_nxt = STOP;
         end
      endcase

      // Timeout only watches states that wait on the remote side.
      counting = (tx_st == ACT) || (tx_st == DEACT) || (rx_st == DEACT);
      if ((tx_nxt != tx_st) || (rx_nxt != rx_st) || !counting)
         to_nxt = '0;
      else if (to_cnt != TO_LIM)
         to_nxt = to_cnt + 1'b1;
      else
         to_nxt = to_cnt;
      err_nxt = err_q || (to_nxt == TO_LIM);
   end

   assign timeout_err = err_q;
   assign state.tx    = tx_st;
   assign state.rx    = rx_st;

endmodule

// File: rtl/chi_link_ctrl.sv
// CHI link-layer activation controller for NUM_LINKS independent ports.
// Each port is one chi_link_lane; all ports are per-link bit vectors.
// Ports:
//   ACLK, ARESETn                        clock, synchronous active-low reset
//   tx_up_req, txlinkactivereq,
//   txlinkactiveack, txlcrdv,
//   tx_flit_send, tx_flit_ok, tx_crd_return   TX side per link
//   rxlinkactivereq, rxlinkactiveack,
//   rx_accept, rxlcrdv, rx_flitv         RX side per link
//   link_state                           per link {tx_state[1:0], rx_state[1:0]}
//   timeout_err                          sticky per-link handshake timeout
module chi_link_ctrl
   import chi_link_pkg::*;
#(
   parameter int NUM_LINKS = 2,
   parameter int MAX_CRD   = 15,
   parameter int TIMEOUT   = 1023
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [NUM_LINKS-1:0]   tx_up_req,
   output logic [NUM_LINKS-1:0]   txlinkactivereq,
   input  logic [NUM_LINKS-1:0]   txlinkactiveack,
   input  logic [NUM_LINKS-1:0]   txlcrdv,
   input  logic [NUM_LINKS-1:0]   tx_flit_send,
   output logic [NUM_LINKS-1:0]   tx_flit_ok,
   output logic [NUM_LINKS-1:0]   tx_crd_return,
   input  logic [NUM_LINKS-1:0]   rxlinkactivereq,
   output logic [NUM_LINKS-1:0]   rxlinkactiveack,
   input  logic [NUM_LINKS-1:0]   rx_accept,
   output logic [NUM_LINKS-1:0]   rxlcrdv,
   input  logic [NUM_LINKS-1:0]   rx_flitv,
   output logic [4*NUM_LINKS-1:0] link_state,
   output logic [NUM_LINKS-1:0]   timeout_err
);

   for (genvar i = 0; i < NUM_LINKS; i++) begin : g_lane
      chi_link_pair_t st;

      chi_link_lane #(
         .MAX_CRD (MAX_CRD),
         .TIMEOUT (TIMEOUT)
      ) u_lane (
         .ACLK            (ACLK),
         .ARESETn         (ARESETn),
         .tx_up_req       (tx_up_req[i]),
         .txlinkactivereq (txlinkactivereq[i]),
         .txlinkactiveack (txlinkactiveack[i]),
         .txlcrdv         (txlcrdv[i]),
         .tx_flit_send    (tx_flit_send[i]),
         .tx_flit_ok      (tx_flit_ok[i]),
         .tx_crd_return   (tx_crd_return[i]),
         .rxlinkactivereq (rxlinkactivereq[i]),
         .rxlinkactiveack (rxlinkactiveack[i]),
         .rx_accept       (rx_accept[i]),
         .rxlcrdv         (rxlcrdv[i]),
         .rx_flitv        (rx_flitv[i]),
         .timeout_err     (timeout_err[i]),
         .state           (st)
      );

      assign link_state[4*i +: 4] = st;
   end

endmodule

// File: tb/tb_chi_link_ctrl.sv
// Scoreboard bench for chi_link_ctrl: expected event cycles are queued when
// stimulus is applied and matched against observed DUT events.
module tb_chi_link_ctrl;

   localparam int NL = 2;
   localparam int MC = 15;
   localparam int TO = 8;

   localparam logic [1:0] S_STOP  = 2'd0;
   localparam logic [1:0] S_ACT   = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DEACT = 2'd3;

   logic          ACLK = 1'b0;
   logic          ARESETn;
   logic [NL-1:0] tx_up_req, txlinkactivereq, txlinkactiveack, txlcrdv;
   logic [NL-1:0] tx_flit_send, tx_flit_ok, tx_crd_return;
   logic [NL-1:0] rxlinkactivereq, rxlinkactiveack, rx_accept, rxlcrdv, rx_flitv;
   logic [NL-1:0] timeout_err;
   logic [4*NL-1:0] link_state;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int exp_q[$];
   int obs_q[$];

   chi_link_ctrl #(.NUM_LINKS(NL), .MAX_CRD(MC), .TIMEOUT(TO)) dut (
      .ACLK            (ACLK),
      .ARESETn         (ARESETn),
      .tx_up_req       (tx_up_req),
      .txlinkactivereq (txlinkactivereq),
      .txlinkactiveack (txlinkactiveack),
      .txlcrdv         (txlcrdv),
      .tx_flit_send    (tx_flit_send),
      .tx_flit_ok      (tx_flit_ok),
      .tx_crd_return   (tx_crd_return),
      .rxlinkactivereq (rxlinkactivereq),
      .rxlinkactiveack (rxlinkactiveack),
      .rx_accept       (rx_accept),
      .rxlcrdv         (rxlcrdv),
      .rx_flitv        (rx_flitv),
      .link_state      (link_state),
      .timeout_err     (timeout_err)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   function automatic logic [1:0] txs(input int l);
      return link_state[4*l+2 +: 2];
   endfunction

   function automatic logic [1:0] rxs(input int l);
      return link_state[4*l +: 2];
   endfunction

   task automatic nxt();
      @(posedge ACLK);
      #1;
   endtask

   task automatic smp();
      @(negedge ACLK);
   endtask

   task automatic idle_inputs();
      tx_up_req = '0; txlinkactiveack = '0; txlcrdv = '0; tx_flit_send = '0;
      rxlinkactivereq = '0; rx_accept = '0; rx_flitv = '0;
   endtask

   task automatic do_reset();
      ARESETn = 1'b0;
      idle_inputs();
      nxt();
      nxt();
      ARESETn = 1'b1;
   endtask

   // Records the cycles in which the selected lane-0 event is seen.
   task automatic collect(input int sel, input int n);
      logic ev;
      for (int i = 0; i < n; i++) begin
         smp();
         case (sel)
            0:       ev = tx_flit_ok[0] & tx_flit_send[0];
            1:       ev = tx_crd_return[0];
            default: ev = rxlcrdv[0];
         endcase
         if (ev) obs_q.push_back(cyc);
         nxt();
      end
   endtask

   task automatic test_reset();
      ARESETn = 1'b0;
      idle_inputs();
      nxt(); nxt(); smp();
      n_cmp++;
      if ({txlinkactivereq, tx_flit_ok, tx_crd_return, rxlinkactiveack, rxlcrdv, timeout_err} !== '0) begin
         n_err++; $display("FAIL reset_outputs: got %b required 0",
            {txlinkactivereq, tx_flit_ok, tx_crd_return, rxlinkactiveack, rxlcrdv, timeout_err});
      end
      n_cmp++;
      if (link_state !== '0) begin
         n_err++; $display("FAIL reset_state: got %h required 0", link_state);
      end
      tx_up_req = '1; rxlinkactivereq = '1; rx_accept = '1;
      nxt(); smp();
      n_cmp++;
      if (link_state !== '0 || txlinkactivereq !== '0) begin
         n_err++; $display("FAIL reset_held_active_inputs: state %h req %b required 0", link_state, txlinkactivereq);
      end
      idle_inputs();
   endtask

   task automatic test_bringup();
      int s, e, o;
      do_reset();
      tx_up_req[0] = 1'b1;
      smp();
      n_cmp++;
      if (txlinkactivereq[0] !== 1'b0) begin
         n_err++; $display("FAIL bringup_req_early: got %b required 0", txlinkactivereq[0]);
      end
      nxt(); smp();
      n_cmp++;
      if (txlinkactivereq[0] !== 1'b1 || txs(0) !== S_ACT) begin
         n_err++; $display("FAIL bringup_act: req %b state %0d required 1/%0d", txlinkactivereq[0], txs(0), S_ACT);
      end
      nxt(); nxt(); nxt();
      txlinkactiveack[0] = 1'b1;
      smp();
      n_cmp++;
      if (txs(0) !== S_ACT) begin
         n_err++; $display("FAIL bringup_wait_ack: state %0d required %0d", txs(0), S_ACT);
      end
      nxt(); smp();
      n_cmp++;
      if (txs(0) !== S_RUN || txlinkactivereq[0] !== 1'b1 || tx_flit_ok[0] !== 1'b0) begin
         n_err++; $display("FAIL bringup_run: state %0d req %b ok %b required %0d/1/0",
            txs(0), txlinkactivereq[0], tx_flit_ok[0], S_RUN);
      end
      nxt(); txlcrdv[0] = 1'b1;
      repeat (4) nxt();
      nxt(); txlcrdv[0] = 1'b0;
      smp();
      n_cmp++;
      if (tx_flit_ok[0] !== 1'b1) begin
         n_err++; $display("FAIL bringup_flit_ok: got %b required 1", tx_flit_ok[0]);
      end
      // Five credits must allow exactly five back-to-back sends.
      nxt();
      tx_flit_send[0] = 1'b1;
      s = cyc;
      for (int k = 0; k < 5; k++) exp_q.push_back(s + k);
      collect(0, 7);
      tx_flit_send[0] = 1'b0;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL bringup_credit_count: got %0d sends required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL bringup_send_cycle: got %0d required %0d", o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_simultaneous();
      int s, e, o;
      txlcrdv[0] = 1'b1;
      nxt(); nxt(); nxt();
      tx_flit_send[0] = 1'b1;
      smp();
      n_cmp++;
      if (tx_flit_ok[0] !== 1'b1) begin
         n_err++; $display("FAIL simul_ok: got %b required 1", tx_flit_ok[0]);
      end
      nxt();
      txlcrdv[0] = 1'b0;
      s = cyc;
      for (int k = 0; k < 3; k++) exp_q.push_back(s + k);
      collect(0, 6);
      tx_flit_send[0] = 1'b0;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL simul_credit_count: got %0d sends required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL simul_send_cycle: got %0d required %0d", o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
      smp();
      n_cmp++;
      if (tx_flit_ok[0] !== 1'b0) begin
         n_err++; $display("FAIL simul_zero_ok: got %b required 0", tx_flit_ok[0]);
      end
   endtask

   task automatic test_teardown();
      int d, e, o;
      nxt();
      txlcrdv[0] = 1'b1;
      repeat (4) nxt();
      txlcrdv[0] = 1'b0;
      tx_up_req[0] = 1'b0;
      nxt(); smp();
      d = cyc;
      n_cmp++;
      if (txlinkactivereq[0] !== 1'b0 || txs(0) !== S_DEACT || tx_crd_return[0] !== 1'b1) begin
         n_err++; $display("FAIL teardown_enter: req %b state %0d ret %b required 0/%0d/1",
            txlinkactivereq[0], txs(0), tx_crd_return[0], S_DEACT);
      end
      for (int k = 1; k < 4; k++) exp_q.push_back(d + k);
      nxt();
      collect(1, 5);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL teardown_returns: got %0d more pulses required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL teardown_return_cycle: got %0d required %0d", o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
      txlinkactiveack[0] = 1'b0;
      smp();
      n_cmp++;
      if (txs(0) !== S_DEACT) begin
         n_err++; $display("FAIL teardown_hold_for_ack: state %0d required %0d", txs(0), S_DEACT);
      end
      nxt(); smp();
      n_cmp++;
      if (txs(0) !== S_STOP || txlinkactivereq[0] !== 1'b0 || timeout_err[0] !== 1'b0) begin
         n_err++; $display("FAIL teardown_stop: state %0d req %b err %b required 0/0/0",
            txs(0), txlinkactivereq[0], timeout_err[0]);
      end
   endtask

   task automatic test_rx_fill();
      int s, d, e, o, hit;
      do_reset();
      rxlinkactivereq[0] = 1'b1;
      rx_accept[0] = 1'b1;
      nxt(); smp();
      n_cmp++;
      if (rxs(0) !== S_ACT || rxlinkactiveack[0] !== 1'b0 || rxlcrdv[0] !== 1'b0) begin
         n_err++; $display("FAIL rx_act: state %0d ack %b grant %b required %0d/0/0",
            rxs(0), rxlinkactiveack[0], rxlcrdv[0], S_ACT);
      end
      nxt();
      s = cyc;
      for (int k = 0; k < MC; k++) exp_q.push_back(s + k);
      collect(2, 18);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++; $display("FAIL rx_grant_count: got %0d required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL rx_grant_cycle: got %0d required %0d", o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
      smp();
      n_cmp++;
      if (rxlcrdv[0] !== 1'b0 || rxlinkactiveack[0] !== 1'b1 || rxs(0) !== S_RUN) begin
         n_err++; $display("FAIL rx_full: grant %b ack %b state %0d required 0/1/%0d",
            rxlcrdv[0], rxlinkactiveack[0], rxs(0), S_RUN);
      end
      // Remote tears down; all 15 outstanding credits come back plus one spare flit.
      nxt();
      rxlinkactivereq[0] = 1'b0;
      nxt(); smp();
      d = cyc;
      n_cmp++;
      if (rxs(0) !== S_DEACT || rxlinkactiveack[0] !== 1'b1) begin
         n_err++; $display("FAIL rx_deact: state %0d ack %b required %0d/1", rxs(0), rxlinkactiveack[0], S_DEACT);
      end
      exp_q.push_back(d + MC + 1);
      rx_flitv[0] = 1'b1;
      hit = -1;
      for (int i = 0; i < 24 && hit < 0; i++) begin
         nxt(); smp();
         if (rxs(0) === S_STOP) hit = cyc;
      end
      rx_flitv[0] = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (hit !== e) begin
         n_err++; $display("FAIL rx_stop_cycle: got %0d required %0d", hit, e);
      end
   endtask

   task automatic test_timeout();
      int k, rise;
      do_reset();
      tx_up_req[0] = 1'b1;
      k = cyc;
      exp_q.push_back(k + 1 + TO);
      rise = -1;
      for (int i = 0; i < 14; i++) begin
         smp();
         if (timeout_err[0] === 1'b1 && rise < 0) rise = cyc;
         nxt();
      end
      n_cmp++;
      if (rise !== exp_q[0]) begin
         n_err++; $display("FAIL timeout_rise_cycle: got %0d required %0d", rise, exp_q[0]);
      end
      exp_q.delete();
      tx_up_req[0] = 1'b0;
      smp();
      n_cmp++;
      if (timeout_err !== 2'b01 || txs(0) !== S_ACT) begin
         n_err++; $display("FAIL timeout_sticky: err %b state %0d required 01/%0d", timeout_err, txs(0), S_ACT);
      end
      nxt();
      txlinkactiveack[0] = 1'b1;
      nxt(); smp();
      n_cmp++;
      if (txs(0) !== S_RUN || timeout_err[0] !== 1'b1) begin
         n_err++; $display("FAIL timeout_fsm_runs: state %0d err %b required %0d/1", txs(0), timeout_err[0], S_RUN);
      end
      ARESETn = 1'b0;
      nxt(); smp();
      n_cmp++;
      if (timeout_err !== '0 || link_state !== '0) begin
         n_err++; $display("FAIL timeout_reset_clear: err %b state %h required 0/0", timeout_err, link_state);
      end
      ARESETn = 1'b1;
      idle_inputs();
   endtask

   task automatic test_reset_mid_run();
      int done;
      do_reset();
      tx_up_req[1] = 1'b1;
      rxlinkactivereq[1] = 1'b1;
      rx_accept[1] = 1'b1;
      done = 0;
      for (int i = 0; i < 12 && done == 0; i++) begin
         nxt(); smp();
         if (txs(1) === S_ACT) txlinkactiveack[1] = 1'b1;
         if (link_state[7:4] === {S_RUN, S_RUN}) done = 1;
      end
      n_cmp++;
      if (done == 0) begin
         n_err++; $display("FAIL mid_bringup_link1: state %h required %h", link_state[7:4], {S_RUN, S_RUN});
      end
      nxt();
      txlcrdv[1] = 1'b1;
      tx_up_req[0] = 1'b1;
      rxlinkactivereq[0] = 1'b1;
      rx_accept[0] = 1'b1;
      nxt();
      txlinkactiveack[0] = 1'b1;
      txlcrdv[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         smp();
         n_cmp++;
         if (link_state[7:4] !== {S_RUN, S_RUN}) begin
            n_err++; $display("FAIL independence_link1: state %h required %h", link_state[7:4], {S_RUN, S_RUN});
         end
         nxt();
      end
      smp();
      n_cmp++;
      if (link_state[3:0] !== {S_RUN, S_RUN} || tx_flit_ok !== 2'b11) begin
         n_err++; $display("FAIL mid_links_running: state %h ok %b required aa/11", link_state, tx_flit_ok);
      end
      ARESETn = 1'b0;
      nxt(); smp();
      n_cmp++;
      if ({txlinkactivereq, tx_flit_ok, tx_crd_return, rxlinkactiveack, rxlcrdv, timeout_err, link_state} !== '0) begin
         n_err++; $display("FAIL mid_run_reset: outputs %b state %h required 0",
            {txlinkactivereq, tx_flit_ok, tx_crd_return, rxlinkactiveack, rxlcrdv, timeout_err}, link_state);
      end
      ARESETn = 1'b1;
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      ARESETn = 1'b0;
      idle_inputs();
      test_reset();
      test_bringup();
      test_simultaneous();
      test_teardown();
      test_rx_fill();
      test_timeout();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
